// File: rtl/sccb_slave_if.sv
// SCCB target pin bundle plus the register-write event port.
interface sccb_slave_if #(
    parameter int unsigned REG_AW = 8
);
    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic              busy;
    logic              wr_valid;
    logic [REG_AW-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport slave  (input  scl_in, sda_in,
                    output sda_oe, busy, wr_valid, wr_addr, wr_data);
    modport master (output scl_in, sda_in,
                    input  sda_oe, busy, wr_valid, wr_addr, wr_data);
endinterface

// File: rtl/sccb_slave.sv
// SCCB/I2C target: device address, register pointer, auto-incrementing burst
// writes and reads on an internal register file, with a write-event pulse.
module sccb_slave #(
    parameter logic [6:0]  DEV_ADDR = 7'h39,
    parameter int unsigned REG_AW   = 8
) (
    input  logic        clk,
    input  logic        rst,
    sccb_slave_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** REG_AW;
    localparam int unsigned CNT_W = 3;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_REG       = 4'd3;
    localparam logic [3:0] S_REG_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_WAIT_STOP = 4'd9;

    // [0],[1] synchronizer, [2] delay for edge detection
    logic [2:0]        r_scl_sync;
    logic [2:0]        r_sda_sync;
    logic              w_scl;
    logic              w_sda;
    logic              w_scl_rise;
    logic              w_scl_fall;
    logic              w_start;
    logic              w_stop;

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic [REG_AW-1:0] r_ptr;
    logic [REG_AW-1:0] w_ptr_nxt;
    logic [REG_AW-1:0] w_ptr_inc;
    logic              r_sda_oe;
    logic              w_sda_oe_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_ack_on;
    logic              w_ack_on_nxt;
    logic              r_rd;
    logic              w_rd_nxt;
    logic              r_wr_valid;
    logic              w_wr_valid_nxt;
    logic [REG_AW-1:0] r_wr_addr;
    logic [REG_AW-1:0] w_wr_addr_nxt;
    logic [7:0]        r_wr_data;
    logic [7:0]        w_wr_data_nxt;
    logic              w_we;
    logic [7:0]        w_byte;
    logic [7:0]        w_rf_cur;
    logic [7:0]        w_rf_inc;

    logic [7:0]        r_regfile [DEPTH];

    // Idle-high reset values keep the first post-reset cycles free of false edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], bus.scl_in};
            r_sda_sync <= {r_sda_sync[1:0], bus.sda_in};
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise =  w_scl & ~r_scl_sync[2];
    assign w_scl_fall = ~w_scl &  r_scl_sync[2];
    assign w_start    =  w_scl &  r_scl_sync[2] &  r_sda_sync[2] & ~w_sda;
    assign w_stop     =  w_scl &  r_scl_sync[2] & ~r_sda_sync[2] &  w_sda;

    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_ptr_inc = r_ptr + REG_AW'(1);
    assign w_rf_cur  = r_regfile[r_ptr];
    assign w_rf_inc  = r_regfile[w_ptr_inc];

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_ptr_nxt      = r_ptr;
        w_sda_oe_nxt   = r_sda_oe;
        w_busy_nxt     = r_busy;
        w_ack_on_nxt   = r_ack_on;
        w_rd_nxt       = r_rd;
        w_wr_valid_nxt = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_we           = 1'b0;

        if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_ack_on_nxt = 1'b0;
        end else if (w_start) begin
            w_state_nxt  = S_ADDR;
            w_cnt_nxt    = '0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b1;
            w_ack_on_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(7)) begin
                            if (r_shift[6:0] == DEV_ADDR) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_rd_nxt    = w_sda;
                            end else begin
                                w_state_nxt  = S_IDLE;
                                w_busy_nxt   = 1'b0;
                                w_sda_oe_nxt = 1'b0;
                            end
                        end
                    end
                end
                S_REG: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(7)) begin
                            w_ptr_nxt   = REG_AW'(w_byte);
                            w_state_nxt = S_REG_ACK;
                        end
                    end
                end
                S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(7)) begin
                            w_we           = 1'b1;
                            w_wr_valid_nxt = 1'b1;
                            w_wr_addr_nxt  = r_ptr;
                            w_wr_data_nxt  = w_byte;
                            w_ptr_nxt      = w_ptr_inc;
                            w_state_nxt    = S_WDATA_ACK;
                        end
                    end
                end
                // First fall pulls SDA low for the ACK, second fall ends the slot
                S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            w_sda_oe_nxt = 1'b1;
                            w_ack_on_nxt = 1'b1;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_ack_on_nxt = 1'b0;
                            w_cnt_nxt    = '0;
                            if (r_state == S_ADDR_ACK && r_rd) begin
                                w_shift_nxt  = w_rf_cur;
                                w_sda_oe_nxt = ~w_rf_cur[7];
                                w_state_nxt  = S_RDATA;
                            end else if (r_state == S_ADDR_ACK) begin
                                w_state_nxt = S_REG;
                            end else begin
                                w_state_nxt = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == CNT_W'(7)) begin
                            w_sda_oe_nxt = 1'b0;
                            w_cnt_nxt    = '0;
                            w_state_nxt  = S_RDATA_ACK;
                        end else begin
                            w_sda_oe_nxt = ~r_shift[6];
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_cnt_nxt    = r_cnt + CNT_W'(1);
                        end
                    end
                end
                // r_ack_on here marks "next byte loaded, MSB goes out on the fall"
                S_RDATA_ACK: begin
                    if (!r_ack_on) begin
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                w_ptr_nxt    = w_ptr_inc;
                                w_shift_nxt  = w_rf_inc;
                                w_ack_on_nxt = 1'b1;
                            end else begin
                                w_sda_oe_nxt = 1'b0;
                                w_state_nxt  = S_WAIT_STOP;
                            end
                        end
                    end else if (w_scl_fall) begin
                        w_sda_oe_nxt = ~r_shift[7];
                        w_ack_on_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_ack_on   <= 1'b0;
            r_rd       <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ptr      <= w_ptr_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_ack_on   <= w_ack_on_nxt;
            r_rd       <= w_rd_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
        end
    end

    // Single write port; reset clears every byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regfile[REG_AW'(i)] <= '0;
            end
        end else if (w_we) begin
            r_regfile[r_ptr] <= w_byte;
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.busy     = r_busy;
    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: bit-banged SCCB master, write scoreboard, register-file model.
module tb_sccb_slave;
    localparam int unsigned REG_AW = 8;
    localparam int          Q      = 100;   // quarter SCL period, 10 clk cycles

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] dev;
        logic [7:0] reg_a;
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       acked;
    } wvec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    wr_t  exp_q[$];
    logic [7:0] mem [256];
    wvec_t vec [5];

    always #5 clk = ~clk;

    sccb_slave_if #(.REG_AW(REG_AW)) bus ();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    sccb_slave #(.DEV_ADDR(7'h39), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Write scoreboard: every wr_valid cycle must match the next expected write
    always @(negedge clk) begin
        if (!rst && bus.wr_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 16'(bus.wr_addr), 16'(e.addr));
                chk("wr_data", 16'(bus.wr_data), 16'(e.data));
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic bit_cyc(input logic b, output logic rx);
        sda_m = b;  #Q;
        scl_m = 1'b1; #Q;
        rx = bus.sda_in; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic do_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic do_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #(4*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic rx;
        for (int i = 7; i >= 0; i--) bit_cyc(b[i], rx);
        bit_cyc(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic rx;
        for (int i = 7; i >= 0; i--) begin
            bit_cyc(1'b1, rx);
            d[i] = rx;
        end
        bit_cyc(nack, rx);
    endtask

    task automatic wr_seq(input wvec_t v);
        logic       ack;
        logic [7:0] a;
        logic [7:0] d;
        wr_t        e;
        do_start();
        send_byte(v.dev, ack);
        chk("dev_ack", 16'(ack), 16'(!v.acked));
        chk("busy_mid", 16'(bus.busy), 16'(v.acked));
        send_byte(v.reg_a, ack);
        chk("reg_ack", 16'(ack), 16'(!v.acked));
        for (int i = 0; i < v.n; i++) begin
            d = (i == 0) ? v.d0 : v.d1;
            a = v.reg_a + 8'(i);
            if (v.acked) begin
                e.addr = a;
                e.data = d;
                exp_q.push_back(e);
                mem[a] = d;
            end
            send_byte(d, ack);
            chk("data_ack", 16'(ack), 16'(!v.acked));
        end
        do_stop();
        chk("busy_after_stop", 16'(bus.busy), 16'(0));
        chk("wr_pending", 16'(exp_q.size()), 16'(0));
    endtask

    task automatic rd_seq(input logic [7:0] ra, input int n);
        logic       ack;
        logic       rx;
        logic [7:0] d;
        logic [7:0] idx;
        do_start();
        send_byte(8'h72, ack);
        chk("rd_dev_w_ack", 16'(ack), 16'(0));
        send_byte(ra, ack);
        chk("rd_reg_ack", 16'(ack), 16'(0));
        do_start();
        send_byte(8'h73, ack);
        chk("rd_dev_r_ack", 16'(ack), 16'(0));
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, d);
            idx = ra + 8'(i);
            chk("rd_data", 16'(d), 16'(mem[idx]));
        end
        chk("rd_nack_release", 16'(bus.sda_oe), 16'(0));
        chk("rd_wait_stop_busy", 16'(bus.busy), 16'(1));
        bit_cyc(1'b1, rx);
        chk("wait_stop_sda_high", 16'(rx), 16'(1));
        do_stop();
        chk("rd_busy_after_stop", 16'(bus.busy), 16'(0));
    endtask

    task automatic reset_bus();
        #Q;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        clear_model();
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic       ack;
        logic       rx;
        logic [7:0] b;

        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sda_oe",   16'(bus.sda_oe),   16'(0));
        chk("rst_busy",     16'(bus.busy),     16'(0));
        chk("rst_wr_valid", 16'(bus.wr_valid), 16'(0));
        chk("rst_wr_addr",  16'(bus.wr_addr),  16'(0));
        chk("rst_wr_data",  16'(bus.wr_data),  16'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        vec[0] = '{8'h72, 8'h41, 1, 8'h10, 8'h00, 1'b1};   // single write
        vec[1] = '{8'h72, 8'hFF, 2, 8'hAA, 8'hBB, 1'b1};   // burst wrapping to 0x00
        vec[2] = '{8'h74, 8'h33, 1, 8'h55, 8'h00, 1'b0};   // wrong device address
        vec[3] = '{8'h72, 8'h16, 1, 8'h5C, 8'h00, 1'b1};
        vec[4] = '{8'h72, 8'h80, 2, 8'h01, 8'hFE, 1'b1};
        for (int i = 0; i < 5; i++) wr_seq(vec[i]);

        rd_seq(8'h16, 2);   // 0x5C then 0x00
        rd_seq(8'hFF, 2);   // read pointer wraps: 0xAA then 0xBB
        rd_seq(8'h80, 2);

        // Reset during the 5th bit of a data byte
        do_start();
        send_byte(8'h72, ack);
        chk("abort_dev_ack", 16'(ack), 16'(0));
        send_byte(8'h20, ack);
        chk("abort_reg_ack", 16'(ack), 16'(0));
        b = 8'hC3;
        for (int i = 7; i >= 4; i--) bit_cyc(b[i], rx);
        sda_m = b[3]; #Q;
        scl_m = 1'b1; #(Q/2);
        rst = 1'b1;
        #1;
        chk("abort_sda_oe", 16'(bus.sda_oe), 16'(0));
        chk("abort_busy",   16'(bus.busy),   16'(0));
        reset_bus();

        wr_seq('{8'h72, 8'h20, 1, 8'h99, 8'h00, 1'b1});
        rd_seq(8'h41, 1);   // cleared by reset
        rd_seq(8'h20, 1);

        // Reset while the target holds SDA low for an ACK
        do_start();
        b = 8'h72;
        for (int i = 7; i >= 0; i--) bit_cyc(b[i], rx);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        chk("ack_slot_drive", 16'(bus.sda_oe), 16'(1));
        rst = 1'b1;
        #1;
        chk("ack_slot_rst_release", 16'(bus.sda_oe), 16'(0));
        reset_bus();

        // Without a START the target must ignore the bus
        scl_m = 1'b0; #Q;
        send_byte(8'h72, ack);
        chk("no_start_no_ack", 16'(ack), 16'(1));
        chk("no_start_busy",   16'(bus.busy), 16'(0));
        rd_seq(8'h20, 1);   // 0x00 after the second reset

        repeat (20) @(negedge clk);
        chk("final_pending", 16'(exp_q.size()), 16'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
